// File: rtl/wb_stage_pipe_pkg.sv
// Shared types for the write-back stage: data/size selects and FSM states.
package wb_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_PC0 = 2'b00,
        SEL_PC1 = 2'b01,
        SEL_MEM = 2'b10,
        SEL_EXE = 2'b11
    } wb_sel_t;

    typedef enum logic [SIZE_W-1:0] {
        LD_BYTE = 2'b00,
        LD_HALF = 2'b01,
        LD_WORD = 2'b10,
        LD_FULL = 2'b11
    } ld_size_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-to-WB bundle plus register-file write and forwarding outputs.
interface wb_stage_pipe_if
    import wb_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned REG_W = 5
);
    localparam int unsigned LANE_W = $clog2(N/8);

    logic              in_valid;
    logic [N-1:0]      exe_out;
    logic [N-1:0]      pc_inc4;
    logic [REG_W-1:0]  rx;
    wb_sel_t           wb_data_sel;
    logic              wb_reg_sel;
    logic              reg_wr;
    ld_size_t          ld_size;
    logic              ld_signed;
    logic [LANE_W-1:0] addr_lo;
    logic              mem_rdy;
    logic [N-1:0]      mem_rdata;
    logic              flush;

    logic              stall_out;
    logic              wb_en;
    logic [REG_W-1:0]  wb_reg;
    logic [N-1:0]      wb_data;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_reg;
    logic [N-1:0]      fwd_data;

    modport master (
        output in_valid, exe_out, pc_inc4, rx, wb_data_sel, wb_reg_sel, reg_wr,
               ld_size, ld_signed, addr_lo, mem_rdy, mem_rdata, flush,
        input  stall_out, wb_en, wb_reg, wb_data, fwd_valid, fwd_reg, fwd_data
    );

    modport slave (
        input  in_valid, exe_out, pc_inc4, rx, wb_data_sel, wb_reg_sel, reg_wr,
               ld_size, ld_signed, addr_lo, mem_rdy, mem_rdata, flush,
        output stall_out, wb_en, wb_reg, wb_data, fwd_valid, fwd_reg, fwd_data
    );

endinterface

// File: rtl/wb_stage_pipe_load_align.sv
// Combinational little-endian load aligner with sign/zero extension.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]             i_mem_rdata,
    input  ld_size_t                 i_ld_size,
    input  logic                     i_ld_signed,
    input  logic [$clog2(N/8)-1:0]   i_addr_lo,
    output logic [N-1:0]             o_data_c
);
    localparam int unsigned LANE_W = $clog2(N/8);
    localparam int unsigned SH_W   = LANE_W + 3;

    logic [LANE_W-1:0] w_lane;
    logic [SH_W-1:0]   w_shamt;
    logic [N-1:0]      w_shifted;
    logic [N-1:0]      w_mask;
    logic              w_msb;
    logic              w_fill;

    // Lane is the offset rounded down to the access alignment.
    always_comb begin
        w_lane = i_addr_lo;
        w_mask = '1;
        w_msb  = 1'b0;
        case (i_ld_size)
            LD_BYTE: ;
            LD_HALF: w_lane = i_addr_lo & ~LANE_W'(1);
            LD_WORD: w_lane = i_addr_lo & ~LANE_W'(3);
            LD_FULL: w_lane = '0;
            default: w_lane = '0;
        endcase
        w_shamt   = {w_lane, 3'b000};
        w_shifted = i_mem_rdata >> w_shamt;
        case (i_ld_size)
            LD_BYTE: begin
                w_mask = N'(8'hFF);
                w_msb  = w_shifted[7];
            end
            LD_HALF: begin
                w_mask = N'(16'hFFFF);
                w_msb  = w_shifted[15];
            end
            LD_WORD: begin
                w_mask = N'(32'hFFFF_FFFF);
                w_msb  = w_shifted[31];
            end
            default: begin
                w_mask = '1;
                w_msb  = 1'b0;
            end
        endcase
        // A full-width mask leaves no bits to fill, so word at N=32 is untouched.
        w_fill   = i_ld_signed & w_msb;
        o_data_c = (w_shifted & w_mask) | ({N{w_fill}} & ~w_mask);
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage: one commit per cycle, stalls upstream while a load is outstanding.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned LR_IDX = 31
) (
    input  logic           clk,
    input  logic           rst,
    wb_stage_pipe_if.slave bus
);
    localparam int unsigned LANE_W = $clog2(N/8);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;

    logic [REG_W-1:0]  r_pend_reg;
    logic              r_pend_wr;
    ld_size_t          r_pend_size;
    logic              r_pend_signed;
    logic [LANE_W-1:0] r_pend_off;

    logic              r_wb_en;
    logic [REG_W-1:0]  r_wb_reg;
    logic [N-1:0]      r_wb_data;

    logic [REG_W-1:0]  w_dest;
    logic              w_commit;
    logic              w_latch;
    logic [REG_W-1:0]  w_commit_reg;
    logic              w_commit_wr;
    logic [N-1:0]      w_commit_data;

    ld_size_t          w_al_size;
    logic              w_al_signed;
    logic [LANE_W-1:0] w_al_off;
    logic [N-1:0]      w_aligned;

    assign w_dest = bus.wb_reg_sel ? bus.rx : REG_W'(LR_IDX);

    // Aligner sees live inputs in IDLE and the latched load in WAIT_MEM.
    assign w_al_size   = (r_state == WAIT_MEM) ? r_pend_size   : bus.ld_size;
    assign w_al_signed = (r_state == WAIT_MEM) ? r_pend_signed : bus.ld_signed;
    assign w_al_off    = (r_state == WAIT_MEM) ? r_pend_off    : bus.addr_lo;

    load_align #(.N(N)) u_align (
        .i_mem_rdata (bus.mem_rdata),
        .i_ld_size   (w_al_size),
        .i_ld_signed (w_al_signed),
        .i_addr_lo   (w_al_off),
        .o_data_c    (w_aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and commit selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_commit      = 1'b0;
        w_latch       = 1'b0;
        w_commit_reg  = w_dest;
        w_commit_wr   = bus.reg_wr;
        w_commit_data = bus.pc_inc4;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    case (bus.wb_data_sel)
                        SEL_EXE: begin
                            w_commit      = 1'b1;
                            w_commit_data = bus.exe_out;
                        end
                        SEL_MEM: begin
                            if (bus.mem_rdy) begin
                                w_commit      = 1'b1;
                                w_commit_data = w_aligned;
                            end else begin
                                w_latch     = 1'b1;
                                w_state_nxt = WAIT_MEM;
                            end
                        end
                        default: w_commit = 1'b1;
                    endcase
                end
            end
            WAIT_MEM: begin
                w_commit_reg  = r_pend_reg;
                w_commit_wr   = r_pend_wr;
                w_commit_data = w_aligned;
                if (bus.flush) begin
                    w_state_nxt = IDLE;
                end else if (bus.mem_rdy) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_reg    <= '0;
            r_pend_wr     <= 1'b0;
            r_pend_size   <= LD_BYTE;
            r_pend_signed <= 1'b0;
            r_pend_off    <= '0;
        end else if (w_latch) begin
            r_pend_reg    <= w_dest;
            r_pend_wr     <= bus.reg_wr;
            r_pend_size   <= bus.ld_size;
            r_pend_signed <= bus.ld_signed;
            r_pend_off    <= bus.addr_lo;
        end
    end

    // Register 0 is never written, but its data still lands in wb_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= w_commit && w_commit_wr && (w_commit_reg != '0);
            if (w_commit) begin
                r_wb_reg  <= w_commit_reg;
                r_wb_data <= w_commit_data;
            end
        end
    end

    assign bus.stall_out = (r_state == WAIT_MEM) && !bus.mem_rdy && !bus.flush;
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_reg    = r_wb_reg;
    assign bus.wb_data   = r_wb_data;
    assign bus.fwd_valid = r_wb_en;
    assign bus.fwd_reg   = r_wb_reg;
    assign bus.fwd_data  = r_wb_data;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: vector table plus load-wait, flush and reset sequences.
module tb_wb_stage_pipe;
    import wb_pkg::*;

    localparam int unsigned N     = 32;
    localparam int unsigned REG_W = 5;

    logic clk;
    logic rst;

    wb_stage_pipe_if #(.N(N), .REG_W(REG_W)) bus ();

    wb_stage_pipe #(.N(N), .REG_W(REG_W), .LR_IDX(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        wb_sel_t     sel;
        logic        reg_sel;
        logic [4:0]  rx;
        logic        reg_wr;
        logic [31:0] exe;
        logic [31:0] pc4;
        ld_size_t    size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic        exp_en;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [4:0]  m_reg   = '0;
    logic [31:0] m_data  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_commit(input logic en, input logic [4:0] rg, input logic [31:0] data);
        exp_t e;
        m_reg  = rg;
        m_data = data;
        e.en = en; e.rg = rg; e.data = data;
        sb.push_back(e);
    endtask

    task automatic push_hold();
        exp_t e;
        e.en = 1'b0; e.rg = m_reg; e.data = m_data;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.exe_out     = '0;
        bus.pc_inc4     = '0;
        bus.rx          = '0;
        bus.wb_data_sel = SEL_PC0;
        bus.wb_reg_sel  = 1'b0;
        bus.reg_wr      = 1'b0;
        bus.ld_size     = LD_BYTE;
        bus.ld_signed   = 1'b0;
        bus.addr_lo     = '0;
        bus.mem_rdy     = 1'b0;
        bus.mem_rdata   = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v, input logic rdy);
        bus.in_valid    = 1'b1;
        bus.wb_data_sel = v.sel;
        bus.wb_reg_sel  = v.reg_sel;
        bus.rx          = v.rx;
        bus.reg_wr      = v.reg_wr;
        bus.exe_out     = v.exe;
        bus.pc_inc4     = v.pc4;
        bus.ld_size     = v.size;
        bus.ld_signed   = v.sgn;
        bus.addr_lo     = v.off;
        bus.mem_rdata   = v.rdata;
        bus.mem_rdy     = rdy;
    endtask

    task automatic chk_stall(input string name, input logic exp);
        #1;
        chk(name, 64'(bus.stall_out), 64'(exp));
    endtask

    // Advance one edge, compare the registered outputs with the oldest expectation.
    task automatic tick(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({name, "_en"},       64'(bus.wb_en),     64'(e.en));
            chk({name, "_reg"},      64'(bus.wb_reg),    64'(e.rg));
            chk({name, "_data"},     64'(bus.wb_data),   64'(e.data));
            chk({name, "_fwd_v"},    64'(bus.fwd_valid), 64'(e.en));
            chk({name, "_fwd_reg"},  64'(bus.fwd_reg),   64'(e.rg));
            chk({name, "_fwd_data"}, 64'(bus.fwd_data),  64'(e.data));
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_en"},    64'(bus.wb_en),     64'd0);
        chk({name, "_reg"},   64'(bus.wb_reg),    64'd0);
        chk({name, "_data"},  64'(bus.wb_data),   64'd0);
        chk({name, "_fv"},    64'(bus.fwd_valid), 64'd0);
        chk({name, "_freg"},  64'(bus.fwd_reg),   64'd0);
        chk({name, "_fdata"}, 64'(bus.fwd_data),  64'd0);
        chk({name, "_stall"}, 64'(bus.stall_out), 64'd0);
    endtask

    function automatic vec_t mk(input wb_sel_t sel, input logic reg_sel, input logic [4:0] rx,
                                input logic reg_wr, input logic [31:0] exe, input logic [31:0] pc4,
                                input ld_size_t size, input logic sgn, input logic [1:0] off,
                                input logic [31:0] rdata, input logic exp_en,
                                input logic [4:0] exp_reg, input logic [31:0] exp_data);
        vec_t v;
        v.sel = sel; v.reg_sel = reg_sel; v.rx = rx; v.reg_wr = reg_wr;
        v.exe = exe; v.pc4 = pc4; v.size = size; v.sgn = sgn; v.off = off;
        v.rdata = rdata; v.exp_en = exp_en; v.exp_reg = exp_reg; v.exp_data = exp_data;
        return v;
    endfunction

    initial begin
        vec_t ld;
        int   stall_cnt;

        rst = 1'b1;
        idle_inputs();

        // Expectations are hand-derived little-endian extensions of the given words.
        vecs.push_back(mk(SEL_EXE, 1, 5'd5,  1, 32'h1234,     32'h0,   LD_BYTE, 0, 2'd0, 32'h0,         1, 5'd5,  32'h0000_1234));
        vecs.push_back(mk(SEL_PC0, 0, 5'd9,  1, 32'h0,        32'h104, LD_BYTE, 0, 2'd0, 32'h0,         1, 5'd31, 32'h0000_0104));
        vecs.push_back(mk(SEL_PC1, 1, 5'd7,  1, 32'h0,        32'h200, LD_BYTE, 0, 2'd0, 32'h0,         1, 5'd7,  32'h0000_0200));
        vecs.push_back(mk(SEL_EXE, 1, 5'd0,  1, 32'hDEAD,     32'h0,   LD_BYTE, 0, 2'd0, 32'h0,         0, 5'd0,  32'h0000_DEAD));
        vecs.push_back(mk(SEL_EXE, 1, 5'd9,  0, 32'h55,       32'h0,   LD_BYTE, 0, 2'd0, 32'h0,         0, 5'd9,  32'h0000_0055));
        vecs.push_back(mk(SEL_MEM, 1, 5'd4,  1, 32'h0,        32'h0,   LD_BYTE, 1, 2'd3, 32'h8000_0000, 1, 5'd4,  32'hFFFF_FF80));
        vecs.push_back(mk(SEL_MEM, 1, 5'd6,  1, 32'h0,        32'h0,   LD_HALF, 0, 2'd2, 32'hBEEF_0000, 1, 5'd6,  32'h0000_BEEF));
        vecs.push_back(mk(SEL_MEM, 1, 5'd6,  1, 32'h0,        32'h0,   LD_HALF, 0, 2'd3, 32'hBEEF_0000, 1, 5'd6,  32'h0000_BEEF));
        vecs.push_back(mk(SEL_MEM, 1, 5'd8,  1, 32'h0,        32'h0,   LD_HALF, 1, 2'd0, 32'h1234_8001, 1, 5'd8,  32'hFFFF_8001));
        vecs.push_back(mk(SEL_MEM, 1, 5'd10, 1, 32'h0,        32'h0,   LD_BYTE, 0, 2'd1, 32'h0000_A500, 1, 5'd10, 32'h0000_00A5));
        vecs.push_back(mk(SEL_MEM, 1, 5'd11, 1, 32'h0,        32'h0,   LD_WORD, 1, 2'd3, 32'h89AB_CDEF, 1, 5'd11, 32'h89AB_CDEF));
        vecs.push_back(mk(SEL_MEM, 1, 5'd12, 1, 32'h0,        32'h0,   LD_FULL, 1, 2'd2, 32'hCAFE_F00D, 1, 5'd12, 32'hCAFE_F00D));
        vecs.push_back(mk(SEL_MEM, 1, 5'd13, 1, 32'h0,        32'h0,   LD_BYTE, 1, 2'd2, 32'h007F_0000, 1, 5'd13, 32'h0000_007F));

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Back-to-back table: one instruction per cycle, loads have mem_rdy in the same cycle.
        foreach (vecs[i]) begin
            drive_vec(vecs[i], 1'b1);
            push_commit(vecs[i].exp_en, vecs[i].exp_reg, vecs[i].exp_data);
            chk_stall($sformatf("vec%0d_stall", i), 1'b0);
            tick($sformatf("vec%0d", i));
        end
        idle_inputs();
        push_hold();
        tick("idle_hold");

        // Signed byte load with three wait cycles; a live ALU op during the wait is ignored.
        ld = mk(SEL_MEM, 1, 5'd3, 1, 32'h0, 32'h0, LD_BYTE, 1, 2'd3, 32'h0, 1, 5'd3, 32'h0);
        drive_vec(ld, 1'b0);
        push_hold();
        chk_stall("ldw_capture_stall", 1'b0);
        tick("ldw_capture");
        stall_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            drive_vec(mk(SEL_EXE, 1, 5'd6, 1, 32'h7777, 32'h0, LD_BYTE, 0, 2'd0, 32'h0, 1, 5'd6, 32'h7777), 1'b0);
            #1;
            if (bus.stall_out === 1'b1) stall_cnt++;
            push_hold();
            tick($sformatf("ldw_wait%0d", c));
        end
        chk("ldw_stall_cycles", 64'(stall_cnt), 64'd3);
        idle_inputs();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 32'h8000_0000;
        push_commit(1'b1, 5'd3, 32'hFFFF_FF80);
        chk_stall("ldw_rdy_stall", 1'b0);
        tick("ldw_done");
        idle_inputs();

        // Flush in WAIT_MEM beats a same-cycle mem_rdy.
        drive_vec(mk(SEL_MEM, 1, 5'd14, 1, 32'h0, 32'h0, LD_WORD, 0, 2'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        push_hold();
        tick("fl_capture");
        idle_inputs();
        chk_stall("fl_wait_stall", 1'b1);
        bus.flush     = 1'b1;
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        push_hold();
        chk_stall("fl_flush_stall", 1'b0);
        tick("fl_flush");
        idle_inputs();
        drive_vec(mk(SEL_EXE, 1, 5'd15, 1, 32'hABCD, 32'h0, LD_BYTE, 0, 2'd0, 32'h0, 1, 5'd15, 32'hABCD), 1'b0);
        push_commit(1'b1, 5'd15, 32'hABCD);
        chk_stall("fl_idle_stall", 1'b0);
        tick("fl_after");

        // Flush in IDLE drops the instruction being captured.
        drive_vec(mk(SEL_EXE, 1, 5'd16, 1, 32'h9999, 32'h0, LD_BYTE, 0, 2'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        bus.flush = 1'b1;
        push_hold();
        tick("fl_idle");
        idle_inputs();

        // Asynchronous reset while waiting on a load.
        drive_vec(mk(SEL_MEM, 1, 5'd17, 1, 32'h0, 32'h0, LD_HALF, 1, 2'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        push_hold();
        tick("rst_capture");
        idle_inputs();
        chk_stall("rst_wait_stall", 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_reg  = '0;
        m_data = '0;
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        push_hold();
        tick("rst_no_commit");
        idle_inputs();
        drive_vec(mk(SEL_EXE, 1, 5'd18, 1, 32'h4242, 32'h0, LD_BYTE, 0, 2'd0, 32'h0, 1, 5'd18, 32'h4242), 1'b0);
        push_commit(1'b1, 5'd18, 32'h4242);
        tick("rst_after");
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
